// File: rtl/nios_system_mem_test_pkg.sv
// Shared types and helpers for the on-chip memory self-test master.
package nios_system_mem_test_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RW   = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Word i of the test pattern; callers truncate to their data width (<= 64 bits).
  function automatic logic [63:0] pattern(input logic [63:0] seed, input logic [63:0] i);
    return seed + i;
  endfunction

endpackage

// File: rtl/nios_system_mem_test_if.sv
// Avalon-MM word-addressed bus between the test master and the memory slave.
interface nios_system_mem_test_if
  import nios_system_mem_test_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // Handshake: a request (read or write high) completes on the cycle it is high
  // with waitrequest low; while waitrequest is high the master holds address,
  // data and request unchanged. readdatavalid qualifies readdata for one cycle,
  // either together with read acceptance or on any later cycle.
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );

endinterface

// File: rtl/nios_system_mem_test_timeout.sv
// Loadable down-counter; expired goes high TIMEOUT-1 enabled cycles after load.
module nios_system_mem_test_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Loading TIMEOUT-1 makes the waiting state last exactly TIMEOUT cycles.
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/nios_system_mem_test_master.sv
// Built-in self-test master: writes seed+i over a word region, reads it back,
// counts mismatches and reports pass/fail, first failing address and timeout.
module nios_system_mem_test_master
  import nios_system_mem_test_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [CNT_W-1:0]      err_count,
  output state_t                dbg_state,
  nios_system_mem_test_if.master avm
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  idx, idx_nx;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] seed_q;
  logic [CNT_W-1:0]  err_count_q, err_count_nx;
  logic [ADDR_W-1:0] err_addr_q, err_addr_nx;
  logic              timeout_q, timeout_nx;
  logic              pass_q, pass_nx;

  logic              last;
  logic              req;
  logic              cmp_en;
  logic              tmr_load;
  logic              tmr_expired;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] exp_data;

  assign last     = (idx == cnt_q - 1'b1);
  assign cur_addr = base_q + ADDR_W'(idx);
  assign exp_data = DATA_W'(pattern(64'(seed_q), 64'(idx)));

  nios_system_mem_test_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (state == RW),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      seed_q      <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      err_count_q <= err_count_nx;
      err_addr_q  <= err_addr_nx;
      timeout_q   <= timeout_nx;
      pass_q      <= pass_nx;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        cnt_q  <= word_count;
        seed_q <= seed;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    err_count_nx = err_count_q;
    err_addr_nx  = err_addr_q;
    timeout_nx   = timeout_q;
    pass_nx      = pass_q;
    cmp_en       = 1'b0;
    tmr_load     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          idx_nx       = '0;
          err_count_nx = '0;
          err_addr_nx  = '0;
          timeout_nx   = 1'b0;
          pass_nx      = 1'b0;
          state_nx     = (word_count == '0) ? FIN : WR;
        end
      end
      WR: begin
        if (!avm.avm_waitrequest) begin
          if (last) begin
            idx_nx   = '0;
            state_nx = RD;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      RD: begin
        if (!avm.avm_waitrequest) begin
          // Zero-latency slave: data arrives with acceptance, so skip RW.
          if (avm.avm_readdatavalid) begin
            cmp_en = 1'b1;
            if (last) begin
              state_nx = FIN;
            end else begin
              idx_nx   = idx + 1'b1;
              state_nx = RD;
            end
          end else begin
            tmr_load = 1'b1;
            state_nx = RW;
          end
        end
      end
      RW: begin
        if (avm.avm_readdatavalid) begin
          cmp_en = 1'b1;
          if (last) begin
            state_nx = FIN;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = RD;
          end
        end else if (tmr_expired) begin
          timeout_nx = 1'b1;
          state_nx   = FIN;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (cmp_en && avm.avm_readdata != exp_data) begin
      if (err_count_q == '0) err_addr_nx = cur_addr;
      if (err_count_q != '1) err_count_nx = err_count_q + 1'b1;
    end

    // Verdict is settled on entry to FIN so it is already valid alongside done.
    if (state_nx == FIN && state != FIN) begin
      pass_nx = (err_count_nx == '0) && !timeout_nx;
    end
  end

  assign req                = (state == WR) || (state == RD);
  assign avm.avm_write      = (state == WR);
  assign avm.avm_read       = (state == RD);
  assign avm.avm_chipselect = req;
  assign avm.avm_byteenable = {(DATA_W/8){req}};
  assign avm.avm_address    = req ? cur_addr : '0;
  assign avm.avm_writedata  = (state == WR) ? exp_data : '0;

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_nios_system_mem_test_master.sv
// Directed + randomized bench for the memory self-test master with a behavioural slave.
module tb_nios_system_mem_test_master;
  import nios_system_mem_test_pkg::*;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 255;
  localparam int BE_W    = DATA_W / 8;
  localparam int AW      = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [DATA_W-1:0] seed;
  logic              busy, done, pass, timeout;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  err_count;
  state_t            dbg_state;

  nios_system_mem_test_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  nios_system_mem_test_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .seed       (seed),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .err_addr   (err_addr),
    .err_count  (err_count),
    .dbg_state  (dbg_state),
    .avm        (avm)
  );

  // ---------------- slave model and scoreboard state ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                lat_mode;      // 0: same-cycle data, 1: next cycle, 2: never
  bit                wait_rand;
  int                corrupt_addr;  // -1: none
  bit                pend;
  logic [DATA_W-1:0] pend_data;
  bit                stalled;
  logic [AW+1:0]     snap;
  int                cyc;
  int                rd_acc_cyc;
  int                n_wr_seen, n_rd_seen;
  logic [AW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_rq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; all slave decisions and checks happen at the falling edge.
  task automatic tick();
    logic [AW+1:0]     now;
    logic [DATA_W-1:0] v;
    logic              rq;
    @(negedge clk);
    cyc++;
    now = {avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata};
    rq  = avm.avm_read | avm.avm_write;
    if (stalled) check("stall_hold", 64'(now), 64'(snap));
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata      = '0;
    if (pend) begin
      avm.avm_readdatavalid = 1'b1;
      avm.avm_readdata      = pend_data;
      pend = 1'b0;
    end
    avm.avm_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rq) begin
      check("chipselect", 64'(avm.avm_chipselect), 64'(1));
      check("byteenable", 64'(avm.avm_byteenable), 64'({BE_W{1'b1}}));
    end else begin
      check("idle_bus", 64'({avm.avm_chipselect, avm.avm_byteenable}), 64'(0));
    end
    if (avm.avm_write && !avm.avm_waitrequest) begin
      n_wr_seen++;
      if (exp_q.size() != 0) check("write_addr_data", 64'({avm.avm_address, avm.avm_writedata}), 64'(exp_q.pop_front()));
      mem[avm.avm_address] = avm.avm_writedata;
    end
    if (avm.avm_read && !avm.avm_waitrequest) begin
      n_rd_seen++;
      rd_acc_cyc = cyc;
      if (exp_rq.size() != 0) check("read_addr", 64'(avm.avm_address), 64'(exp_rq.pop_front()));
      v = mem[avm.avm_address];
      if (corrupt_addr == int'(avm.avm_address)) v[0] = ~v[0];
      if (lat_mode == 0) begin
        avm.avm_readdatavalid = 1'b1;
        avm.avm_readdata      = v;
      end else if (lat_mode == 1) begin
        pend      = 1'b1;
        pend_data = v;
      end
    end
    stalled = rq && avm.avm_waitrequest;
    snap    = now;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_status"}, 64'({busy, done, pass, timeout}), 64'(0));
    check({tag, "_err_addr"}, 64'(err_addr), 64'(0));
    check({tag, "_err_count"}, 64'(err_count), 64'(0));
    check({tag, "_avm_ctrl"}, 64'({avm.avm_read, avm.avm_write, avm.avm_chipselect, avm.avm_byteenable}), 64'(0));
    check({tag, "_avm_addr"}, 64'(avm.avm_address), 64'(0));
    check({tag, "_avm_wdata"}, 64'(avm.avm_writedata), 64'(0));
  endtask

  // Runs one test; expected results derived from pattern/address arithmetic.
  task automatic run_test(input string tag, input int base, input int count, input logic [DATA_W-1:0] sd,
                          input int lat, input bit wr, input int corrupt, input bit poke);
    int                s, e_cnt, e_addr, a, e_lat, e_reads;
    bit                e_to, e_pass;
    exp_q.delete();
    exp_rq.delete();
    e_cnt = 0; e_addr = 0;
    e_to    = (lat == 2) && (count > 0);
    e_reads = (lat == 2) ? ((count > 0) ? 1 : 0) : count;
    for (int i = 0; i < count; i++) begin
      a = (base + i) % (1 << ADDR_W);
      exp_q.push_back({ADDR_W'(a), sd + DATA_W'(i)});
      if (i < e_reads) exp_rq.push_back(ADDR_W'(a));
      if (lat != 2 && a == corrupt) begin
        if (e_cnt == 0) e_addr = a;
        e_cnt++;
      end
    end
    e_pass = (e_cnt == 0) && !e_to;
    e_lat  = (lat == 1) ? 3 * count + 1 : 2 * count + 1;
    lat_mode = lat; wait_rand = wr; corrupt_addr = corrupt;
    n_wr_seen = 0; n_rd_seen = 0;

    base_addr = ADDR_W'(base); word_count = CNT_W'(count); seed = sd;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    check({tag, "_first_write"}, 64'(avm.avm_write), 64'(count > 0));
    while (!done && (cyc - s) < 3000) begin
      if (poke && (cyc - s) == 3) begin
        base_addr = ADDR_W'(base + 7); word_count = CNT_W'(1); seed = ~sd;
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    check({tag, "_pass"}, 64'(pass), 64'(e_pass));
    check({tag, "_err_count"}, 64'(err_count), 64'(e_cnt));
    check({tag, "_err_addr"}, 64'(err_addr), 64'(e_addr));
    check({tag, "_timeout"}, 64'(timeout), 64'(e_to));
    if (e_to) check({tag, "_timeout_latency"}, 64'(cyc - rd_acc_cyc), 64'(TIMEOUT + 1));
    else if (!wr) check({tag, "_done_latency"}, 64'(cyc - s), 64'(e_lat));
    if (poke) begin
      base_addr = ADDR_W'(base + 3); word_count = CNT_W'(2);
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    check({tag, "_done_pulse"}, 64'({done, busy}), 64'(0));
    check({tag, "_pass_hold"}, 64'(pass), 64'(e_pass));
    check({tag, "_write_count"}, 64'(n_wr_seen), 64'(count));
    check({tag, "_read_count"}, 64'(n_rd_seen), 64'(e_reads));
    tick();
    check({tag, "_idle_bus_after"}, 64'({avm.avm_read, avm.avm_write, busy}), 64'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base, count, corrupt;
    logic [CNT_W-1:0] ec;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    avm.avm_readdata = '0; avm.avm_waitrequest = 1'b0; avm.avm_readdatavalid = 1'b0;
    lat_mode = 1; wait_rand = 1'b0; corrupt_addr = -1; pend = 1'b0; pend_data = '0;
    stalled = 1'b0; snap = '0; cyc = 0; rd_acc_cyc = 0; n_wr_seen = 0; n_rd_seen = 0;
    tick(); tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    run_test("basic",    'h0010, 4, 32'hA5A5_0000, 1, 1'b0, -1,      1'b0);
    run_test("corrupt",  'h0010, 4, 32'hA5A5_0000, 1, 1'b0, 'h0012,  1'b0);
    run_test("wrap",     'h7FFE, 4, 32'h1234_5678, 1, 1'b1, -1,      1'b0);
    run_test("zero_cnt", 'h0100, 0, 32'hDEAD_BEEF, 1, 1'b0, -1,      1'b0);
    run_test("no_rdv",   'h0020, 3, 32'h0000_0001, 2, 1'b0, -1,      1'b0);
    run_test("lat0",     'h7FFC, 6, 32'hFFFF_FFFE, 0, 1'b0, 'h0001,  1'b0);
    run_test("ign_start",'h0200, 5, 32'h0BAD_F00D, 1, 1'b0, 'h0203,  1'b1);

    // Stray readdatavalid while idle must leave results untouched.
    ec = err_count;
    pend = 1'b1; pend_data = 32'h5555_AAAA;
    tick(); tick();
    check("stray_rdv", 64'({busy, err_count}), 64'({1'b0, ec}));

    // Reset in the middle of the write phase aborts immediately.
    lat_mode = 1; wait_rand = 1'b0;
    base_addr = ADDR_W'('h0300); word_count = CNT_W'(8); seed = 32'h0F0F_0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mid_wr_write", 64'(avm.avm_write), 64'(1));
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    exp_q.delete(); exp_rq.delete(); pend = 1'b0; stalled = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_zero("post_reset");
    run_test("after_reset", 'h0300, 8, 32'h0F0F_0F0F, 1, 1'b0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      base    = int'($urandom_range(0, (1 << ADDR_W) - 1));
      count   = int'($urandom_range(1, 24));
      corrupt = ($urandom_range(0, 1) == 1) ? (base + int'($urandom_range(0, count - 1))) % (1 << ADDR_W) : -1;
      run_test($sformatf("rand%0d", r), base, count, $urandom(), int'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), corrupt, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
